// File: rtl/host_fifo_pkg.sv
// rtl/host_fifo_pkg.sv - shared host FIFO packet size encoding
// Purpose: size-code constants and payload-length lookup shared by every
// block that parses host FIFO packet headers (header bits [6:4]).
// Ports: none (package).
package host_fifo_pkg;

  localparam int unsigned PAY_W = 4;

  localparam logic [2:0] FIFO_D0 = 3'd0;
  localparam logic [2:0] FIFO_D1 = 3'd1;
  localparam logic [2:0] FIFO_D2 = 3'd2;
  localparam logic [2:0] FIFO_D4 = 3'd3;
  localparam logic [2:0] FIFO_D8 = 3'd4;

  // Payload byte count following a header; reserved codes 5..7 carry nothing.
  function automatic logic [PAY_W-1:0] fifo_payload(input logic [2:0] code);
    case (code)
      FIFO_D0: fifo_payload = 4'd0;
      FIFO_D1: fifo_payload = 4'd1;
      FIFO_D2: fifo_payload = 4'd2;
      FIFO_D4: fifo_payload = 4'd4;
      FIFO_D8: fifo_payload = 4'd8;
      default: fifo_payload = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/host_fifo_arb_rr.sv
// rtl/host_fifo_arb_rr.sv - 2-way packet-granular round-robin grant unit
// Purpose: picks which client's response packet goes next and remembers the
// owner of the last completed packet so ties alternate.
// Ports:
//   i_clk, i_resetn : clock, synchronous active-low reset
//   i_req[1:0]      : client n has a buffered response byte
//   i_take          : latch o_pick as the current grant
//   i_done          : current granted packet finished; it becomes "last"
//   o_pick          : combinational choice for the next grant
//   o_gnt           : registered current grant
module host_fifo_rr (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic [1:0] i_req,
  input  logic       i_take,
  input  logic       i_done,
  output logic       o_pick,
  output logic       o_gnt
);

  logic r_gnt;
  logic r_last;
  logic w_pick;

  always_comb begin
    w_pick = 1'b0;
    if (i_req == 2'b11) begin
      w_pick = ~r_last;
    end else if (i_req[1]) begin
      w_pick = 1'b1;
    end
  end

  // last resets to 1 so client 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_gnt  <= 1'b0;
      r_last <= 1'b1;
    end else begin
      if (i_take) r_gnt  <= w_pick;
      if (i_done) r_last <= r_gnt;
    end
  end

  assign o_pick = w_pick;
  assign o_gnt  = r_gnt;

endmodule

// File: rtl/host_fifo_arb.sv
// rtl/host_fifo_arb.sv - shares one host byte-FIFO pair between two bridges
// Purpose: steers inbound command packets to client hdr[7]; schedules
// outbound response packets round-robin, one whole packet at a time.
// Ports:
//   CLK, RESETn            : clock, synchronous active-low reset
//   RDEN/RDEMPTY/RDDATA    : host read FIFO (data valid the cycle after RDEN)
//   WREN/WRFULL/WRDATA     : host write FIFO
//   C_RDEN/C_RDEMPTY       : per-client inbound pop / empty
//   C_RDDATA               : inbound byte, valid the cycle after a pop
//   C_WREN/C_WRFULL        : per-client response push / full
//   C_WRDATA0, C_WRDATA1   : client response bytes
module host_fifo_arb
  import host_fifo_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  output logic       RDEN,
  input  logic       RDEMPTY,
  input  logic [7:0] RDDATA,
  output logic       WREN,
  input  logic       WRFULL,
  output logic [7:0] WRDATA,
  input  logic [1:0] C_RDEN,
  output logic [1:0] C_RDEMPTY,
  output logic [7:0] C_RDDATA,
  input  logic [1:0] C_WREN,
  output logic [1:0] C_WRFULL,
  input  logic [7:0] C_WRDATA0,
  input  logic [7:0] C_WRDATA1
);

  typedef enum logic {I_HDR, I_PAY} in_state_t;
  typedef enum logic {O_IDLE, O_XFER} out_state_t;

  // ---------------- inbound ----------------
  in_state_t        r_istate, w_istate_nxt;
  logic [7:0]       r_hbuf;
  logic             r_hvalid;
  logic             r_inflt;
  logic             r_dst;
  logic [PAY_W-1:0] r_rem;
  logic [7:0]       r_c_rddata;
  logic             w_dst_cur;
  logic             w_pop;
  logic             w_rden;
  logic [PAY_W-1:0] w_hdr_pay;

  always_comb begin
    w_dst_cur    = (r_istate == I_HDR) ? r_hbuf[7] : r_dst;
    w_pop        = r_hvalid & C_RDEN[w_dst_cur];
    // Reset gate keeps a host byte from being popped into cleared state.
    w_rden       = RESETn & ~RDEMPTY & ~r_inflt & (~r_hvalid | w_pop);
    w_hdr_pay    = fifo_payload(r_hbuf[6:4]);
    w_istate_nxt = r_istate;
    case (r_istate)
      I_HDR: if (w_pop && (w_hdr_pay != '0)) w_istate_nxt = I_PAY;
      I_PAY: if (w_pop && (r_rem == 4'd1)) w_istate_nxt = I_HDR;
      default: w_istate_nxt = I_HDR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_istate   <= I_HDR;
      r_hbuf     <= '0;
      r_hvalid   <= 1'b0;
      r_inflt    <= 1'b0;
      r_dst      <= 1'b0;
      r_rem      <= '0;
      r_c_rddata <= '0;
    end else begin
      r_istate <= w_istate_nxt;
      r_inflt  <= w_rden;
      // A read only launches once hbuf is free, so load and pop never collide.
      if (r_inflt) begin
        r_hbuf   <= RDDATA;
        r_hvalid <= 1'b1;
      end else if (w_pop) begin
        r_hvalid <= 1'b0;
      end
      if (w_pop) begin
        r_c_rddata <= r_hbuf;
        if (r_istate == I_HDR) begin
          r_dst <= r_hbuf[7];
          r_rem <= w_hdr_pay;
        end else begin
          r_rem <= r_rem - 4'd1;
        end
      end
    end
  end

  assign RDEN      = w_rden;
  assign C_RDEMPTY = {~(r_hvalid & w_dst_cur), ~(r_hvalid & ~w_dst_cur)};
  assign C_RDDATA  = r_c_rddata;

  // ---------------- outbound ----------------
  out_state_t       r_ostate, w_ostate_nxt;
  logic [7:0]       r_obuf [2];
  logic [1:0]       r_ovalid;
  logic [PAY_W-1:0] r_ocnt;
  logic             r_ohdr;
  logic             r_wren;
  logic [7:0]       r_wrdata;
  logic             w_pick;
  logic             w_gnt;
  logic             w_take;
  logic             w_wr;
  logic             w_done;
  logic [PAY_W-1:0] w_pick_pay;
  logic [7:0]       w_out_byte;

  always_comb begin
    w_take       = (r_ostate == O_IDLE) & (|r_ovalid);
    w_wr         = (r_ostate == O_XFER) & r_ovalid[w_gnt] & ~WRFULL;
    w_done       = w_wr & (r_ocnt == 4'd1);
    w_pick_pay   = fifo_payload(r_obuf[w_pick][6:4]);
    // The header carries the source interface, whatever the client wrote.
    w_out_byte   = r_ohdr ? {w_gnt, r_obuf[w_gnt][6:0]} : r_obuf[w_gnt];
    w_ostate_nxt = r_ostate;
    case (r_ostate)
      O_IDLE: if (w_take) w_ostate_nxt = O_XFER;
      O_XFER: if (w_done) w_ostate_nxt = O_IDLE;
      default: w_ostate_nxt = O_IDLE;
    endcase
  end

  host_fifo_rr u_rr (
    .i_clk    (CLK),
    .i_resetn (RESETn),
    .i_req    (r_ovalid),
    .i_take   (w_take),
    .i_done   (w_done),
    .o_pick   (w_pick),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_ostate  <= O_IDLE;
      r_obuf[0] <= '0;
      r_obuf[1] <= '0;
      r_ovalid  <= 2'b00;
      r_ocnt    <= '0;
      r_ohdr    <= 1'b0;
      r_wren    <= 1'b0;
      r_wrdata  <= '0;
    end else begin
      r_ostate <= w_ostate_nxt;
      r_wren   <= w_wr;
      if (w_take) begin
        r_ocnt <= 4'd1 + w_pick_pay;
        r_ohdr <= 1'b1;
      end
      if (w_wr) begin
        r_wrdata <= w_out_byte;
        r_ohdr   <= 1'b0;
        r_ocnt   <= r_ocnt - 4'd1;
      end
      // Pushes into a full buffer are dropped; consume needs a full buffer,
      // so fill and drain of the same buffer are mutually exclusive.
      if (C_WREN[0] && !r_ovalid[0]) begin
        r_obuf[0]   <= C_WRDATA0;
        r_ovalid[0] <= 1'b1;
      end else if (w_wr && !w_gnt) begin
        r_ovalid[0] <= 1'b0;
      end
      if (C_WREN[1] && !r_ovalid[1]) begin
        r_obuf[1]   <= C_WRDATA1;
        r_ovalid[1] <= 1'b1;
      end else if (w_wr && w_gnt) begin
        r_ovalid[1] <= 1'b0;
      end
    end
  end

  assign WREN     = r_wren;
  assign WRDATA   = r_wrdata;
  assign C_WRFULL = r_ovalid;

endmodule

// File: tb/tb_host_fifo_arb.sv
// tb/tb_host_fifo_arb.sv - randomized self-checking bench for host_fifo_arb
module tb_host_fifo_arb;

  typedef logic [7:0] bq_t [$];

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       RDEN;
  logic       RDEMPTY = 1'b1;
  logic [7:0] RDDATA = 8'h00;
  logic       WREN;
  logic       WRFULL = 1'b0;
  logic [7:0] WRDATA;
  logic [1:0] C_RDEN = 2'b00;
  logic [1:0] C_RDEMPTY;
  logic [7:0] C_RDDATA;
  logic [1:0] C_WREN = 2'b00;
  logic [1:0] C_WRFULL;
  logic [7:0] C_WRDATA0 = 8'h00;
  logic [7:0] C_WRDATA1 = 8'h00;

  host_fifo_arb dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .RDEN      (RDEN),
    .RDEMPTY   (RDEMPTY),
    .RDDATA    (RDDATA),
    .WREN      (WREN),
    .WRFULL    (WRFULL),
    .WRDATA    (WRDATA),
    .C_RDEN    (C_RDEN),
    .C_RDEMPTY (C_RDEMPTY),
    .C_RDDATA  (C_RDDATA),
    .C_WREN    (C_WREN),
    .C_WRFULL  (C_WRFULL),
    .C_WRDATA0 (C_WRDATA0),
    .C_WRDATA1 (C_WRDATA1)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  bq_t host_q, host_rx, tx0, tx1, rx0, rx1;
  bq_t exp_in0, exp_in1, exp_out0, exp_out1, e;
  logic [1:0] pend_rd = 2'b00;
  logic       prev_wrfull = 1'b0;
  int pop_pct = 100, push_pct = 100, full_pct = 0, junk_pct = 0, full_cnt = 0;
  bit track_c1 = 1'b0;
  int c1_early = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  // Payload length straight from the size table: 0,1,2,4,8 then reserved.
  function automatic int ref_pay(input logic [7:0] hdr);
    int code = int'(hdr[6:4]);
    if (code == 0 || code > 4) return 0;
    return 1 << (code - 1);
  endfunction

  task automatic add_in_pkt(input logic [7:0] hdr);
    logic [7:0] b;
    for (int k = 0; k <= ref_pay(hdr); k++) begin
      b = (k == 0) ? hdr : 8'($urandom);
      host_q.push_back(b);
      if (hdr[7]) exp_in1.push_back(b); else exp_in0.push_back(b);
    end
  endtask

  task automatic add_out_pkt(input bit n, input logic [7:0] hdr);
    logic [7:0] b;
    for (int k = 0; k <= ref_pay(hdr); k++) begin
      b = (k == 0) ? hdr : 8'($urandom);
      if (n) tx1.push_back(b); else tx0.push_back(b);
      if (k == 0) b[7] = n;
      if (n) exp_out1.push_back(b); else exp_out0.push_back(b);
    end
  endtask

  // Host stream must be whole packets, each matching its source's next packet.
  task automatic check_out();
    int i = 0;
    int len;
    logic [7:0] h;
    while (i < host_rx.size()) begin
      h = host_rx[i];
      len = 1 + ref_pay(h);
      if (i + len > host_rx.size()) begin
        chk("out_trunc", host_rx.size(), i + len);
        break;
      end
      for (int k = 0; k < len; k++) begin
        if (h[7]) begin
          if (exp_out1.size() == 0) chk("out1_extra", exp_out1.size(), 1);
          else chk("out1", host_rx[i+k], exp_out1.pop_front());
        end else begin
          if (exp_out0.size() == 0) chk("out0_extra", exp_out0.size(), 1);
          else chk("out0", host_rx[i+k], exp_out0.pop_front());
        end
      end
      i += len;
    end
    chk("out0_left", exp_out0.size(), 0);
    chk("out1_left", exp_out1.size(), 0);
  endtask

  task automatic step();
    logic [1:0] rden;
    logic [1:0] wren;
    @(posedge CLK); #1;
    if (WREN) begin
      chk("wren_while_full", prev_wrfull, 0);
      host_rx.push_back(WRDATA);
    end
    if (pend_rd[0]) rx0.push_back(C_RDDATA);
    if (pend_rd[1]) rx1.push_back(C_RDDATA);
    if (track_c1 && !C_RDEMPTY[1] && rx0.size() < 3) c1_early++;
    RDEMPTY = (host_q.size() == 0);
    rden = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (!C_RDEMPTY[n] && $urandom_range(99) < pop_pct) rden[n] = 1'b1;
      if (C_RDEMPTY[n] && $urandom_range(99) < junk_pct) rden[n] = 1'b1;
    end
    C_RDEN  = rden;
    pend_rd = rden & ~C_RDEMPTY;
    wren = 2'b00;
    if (!C_WRFULL[0] && tx0.size() > 0 && $urandom_range(99) < push_pct) begin
      wren[0] = 1'b1;
      C_WRDATA0 = tx0.pop_front();
    end
    if (!C_WRFULL[1] && tx1.size() > 0 && $urandom_range(99) < push_pct) begin
      wren[1] = 1'b1;
      C_WRDATA1 = tx1.pop_front();
    end
    C_WREN = wren;
    if (full_cnt > 0) begin
      WRFULL = 1'b1;
      full_cnt--;
    end else begin
      WRFULL = ($urandom_range(99) < full_pct);
    end
    prev_wrfull = WRFULL;
    #1;
    if (RDEN) begin
      if (host_q.size() == 0) chk("rden_on_empty", RDEN, 0);
      else RDDATA = host_q.pop_front();
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESETn = 1'b0;
    C_RDEN = 2'b00;
    C_WREN = 2'b00;
    WRFULL = 1'b0;
    @(posedge CLK); #1;
    chk("rst_RDEN", RDEN, 0);
    chk("rst_WREN", WREN, 0);
    chk("rst_WRDATA", WRDATA, 0);
    chk("rst_C_RDEMPTY", C_RDEMPTY, 2'b11);
    chk("rst_C_WRFULL", C_WRFULL, 2'b00);
    chk("rst_C_RDDATA", C_RDDATA, 0);
    RESETn = 1'b1;
    host_q.delete(); host_rx.delete(); tx0.delete(); tx1.delete();
    rx0.delete(); rx1.delete(); exp_in0.delete(); exp_in1.delete();
    exp_out0.delete(); exp_out1.delete();
    pend_rd = 2'b00; prev_wrfull = 1'b0; full_cnt = 0; RDEMPTY = 1'b1;
  endtask

  task automatic run_until(input int budget, input int n_out, input int n_in);
    int c = 0;
    while (c < budget && !(host_q.size() == 0 && tx0.size() == 0 && tx1.size() == 0 &&
           host_rx.size() >= n_out && rx0.size() + rx1.size() >= n_in)) begin
      step();
      c++;
    end
    chk("drain_in_budget", c < budget, 1);
    repeat (4) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    do_reset();

    // Inbound steering, client 1 stays empty until its header is held.
    host_q = '{8'h20, 8'hAA, 8'hBB, 8'h80};
    track_c1 = 1'b1;
    run_until(200, 0, 4);
    track_c1 = 1'b0;
    e = '{8'h20, 8'hAA, 8'hBB}; cmp_q("in_basic0", rx0, e);
    e = '{8'h80};               cmp_q("in_basic1", rx1, e);
    chk("c1_empty_until_hdr", c1_early, 0);

    // Reserved size code carries no payload.
    do_reset();
    host_q = '{8'h70, 8'h85, 8'h10, 8'h01};
    run_until(200, 0, 4);
    e = '{8'h70, 8'h10, 8'h01}; cmp_q("in_rsvd0", rx0, e);
    e = '{8'h85};               cmp_q("in_rsvd1", rx1, e);

    // Reset in the middle of an inbound packet.
    do_reset();
    host_q = '{8'h30, 8'h01, 8'h02, 8'h03, 8'h04};
    c = 0;
    while (rx0.size() < 2 && c < 200) begin step(); c++; end
    chk("mid_pkt_reach", rx0.size() >= 2, 1);
    do_reset();
    host_q = '{8'h10, 8'h01};
    run_until(200, 0, 2);
    e = '{8'h10, 8'h01}; cmp_q("in_after_rst0", rx0, e);
    e = {};              cmp_q("in_after_rst1", rx1, e);

    // Simultaneous responses right after reset.
    do_reset();
    tx0 = '{8'h00};
    tx1 = '{8'h10, 8'h55};
    run_until(200, 3, 0);
    e = '{8'h00, 8'h90, 8'h55}; cmp_q("out_simul", host_rx, e);

    // Fairness with both clients streaming 1-byte packets.
    do_reset();
    e = {};
    for (int k = 0; k < 6; k++) begin
      tx0.push_back(8'h00); tx1.push_back(8'h00);
      e.push_back(8'h00);   e.push_back(8'h80);
    end
    run_until(400, 12, 0);
    cmp_q("out_fair", host_rx, e);

    // Back-pressure during a 5-byte packet, other client waiting.
    do_reset();
    tx0 = '{8'h30, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    c = 0;
    while (host_rx.size() == 0 && c < 100) begin step(); c++; end
    chk("bp_first_byte", host_rx.size(), 1);
    full_cnt = 10;
    tx1.push_back(8'h00);
    run_until(300, 6, 0);
    e = '{8'h30, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h80}; cmp_q("out_bp", host_rx, e);

    // Randomized traffic in both directions against the packet model.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      pop_pct  = (r == 0) ? 60 : 35;
      push_pct = (r == 0) ? 70 : 40;
      full_pct = (r == 0) ? 25 : 50;
      junk_pct = 20;
      for (int k = 0; k < 12; k++) add_in_pkt(8'($urandom));
      for (int k = 0; k < 5; k++) begin
        add_out_pkt(1'b0, 8'($urandom));
        add_out_pkt(1'b1, 8'($urandom));
      end
      run_until(8000, exp_out0.size() + exp_out1.size(), exp_in0.size() + exp_in1.size());
      cmp_q($sformatf("rnd%0d_in0", r), rx0, exp_in0);
      cmp_q($sformatf("rnd%0d_in1", r), rx1, exp_in1);
      check_out();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
